addsub_accumulator: RTL
=======================

Name: addsub_accumulator

Overview:
Sequential driver and consumer of signed add/subtract operations. It accepts a stream of signed operands, each tagged add or subtract, over a valid/ready handshake and folds them into a running signed accumulator. Overflow is detected with the team's sign-extension rule: a one-bit-wider result is formed, and overflow is flagged when its top two bits differ. At end of frame it presents the final value, a sticky overflow flag and the operand count on an output handshake. It sits between the operand sequencer and result logging in the datapath.

Parameters:
WIDTH, 8, operand and accumulator width in bits (two's complement)
CNT_W, 8, operand counter width; count saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand present
in_ready  output  1  block can accept an operand
in_data  input  WIDTH  signed operand
in_op  input  1  0: acc + in_data, 1: acc - in_data
in_last  input  1  marks the final operand of a frame
out_valid  output  1  frame result available
out_ready  input  1  consumer accepts the result
out_acc  output  WIDTH  signed final accumulator value
out_overflow  output  1  sticky; set if any step in the frame overflowed
out_count  output  CNT_W  number of operands accepted in the frame

Behaviour:
- Reset: rst=1 sampled on a clk edge forces state=ACCUM, acc=0, ovf=0, count=0, in_ready=1, out_valid=0, out_acc=0, out_overflow=0, out_count=0. rst has priority over every other event, including mid-frame and while out_valid=1; any partial frame is discarded.
- States: ACCUM and DONE.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Transfer occurs when in_valid and in_ready are both 1 on a clk edge.
  - On a transfer: form tmp = sext(acc) +/- sext(in_data), WIDTH+1 bits. step_ovf = tmp[WIDTH] != tmp[WIDTH-1].
  - acc <= tmp[WIDTH-1:0] (wraps). ovf <= ovf | step_ovf. count <= count+1, saturating at all-ones.
  - If in_last is also 1: move to DONE and load out_acc, out_overflow and out_count from the updated values.
- DONE:
  - in_ready=0 and out_valid=1. Outputs hold stable until the output handshake completes.
  - When out_ready=1: return to ACCUM, clear acc, ovf and count, and drop out_valid on the next cycle.
  - in_valid is ignored while in DONE.
- Latency: one operand per cycle. out_valid rises the cycle after the in_last transfer.
- Throughput: minimum one bubble cycle between frames, because in_ready=0 during DONE.
- out_acc, out_overflow and out_count keep their last values after the handshake until the next frame completes.
- Single-operand frame (in_last on the first transfer): the result is 0 +/- in_data. For subtraction of -2^(WIDTH-1) this overflows.
- Count saturation: after 2^CNT_W-1 operands, count holds. acc and ovf keep updating.
- in_data, in_op and in_last are don't-care when in_valid=0.

Optional Feature:
ADDSUB_ACC_SATURATE_EN
- Defined: on step_ovf, acc is clamped instead of wrapped. Positive overflow (tmp[WIDTH]=0) clamps to +2^(WIDTH-1)-1. Negative overflow clamps to -2^(WIDTH-1). The sticky ovf is still set. Later steps continue from the clamped value.
- Undefined: acc takes tmp[WIDTH-1:0] (two's-complement wrap), exactly as described above.

Test Plan:
- Frame +15, +20 (in_last on 2nd), out_ready=1 -> out_valid one cycle after last transfer, out_acc=35, out_overflow=0, out_count=2; in_ready=0 while out_valid=1.
- Frame +50, -25 (sub), -10 (add, last) -> out_acc=15, ovf=0, count=3.
- Frame +100, +30 (last) -> wrap build: out_acc=-126, ovf=1. ADDSUB_ACC_SATURATE_EN build: out_acc=+127, ovf=1.
- Frame -100, -30, then +50 (last) -> wrap build: out_acc=-80, ovf=1 (sticky). Saturate build: acc=-128 after step 2, then out_acc=-78, ovf=1.
- Single operand 0x80 with op=1 (0 - (-128)) -> wrap build: out_acc=-128, ovf=1. Saturate build: out_acc=+127, ovf=1.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, no operands accepted. Assert rst for one cycle mid-frame after 2 operands -> all outputs zero, in_ready=1; next frame of +1 (last) gives out_acc=1, count=1.

Source files
------------

// File: rtl/addsub_accumulator.sv
// rtl/addsub_accumulator.sv - signed add/subtract frame accumulator with sticky overflow and operand count
// Optional clamping on overflow: define ADDSUB_ACC_SATURATE_EN (default build wraps).
module addsub_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   tmp;
    logic             step_ovf;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] count_next;

    // Next-state arithmetic for one operand: one-bit-wider sum/difference, overflow when top two bits differ
    always_comb begin
        tmp = '0;
        if (in_op)
            tmp = {acc[WIDTH-1], acc} - {in_data[WIDTH-1], in_data};
        else
            tmp = {acc[WIDTH-1], acc} + {in_data[WIDTH-1], in_data};
        step_ovf = tmp[WIDTH] ^ tmp[WIDTH-1];
`ifdef ADDSUB_ACC_SATURATE_EN
        if (step_ovf)
            acc_next = tmp[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            acc_next = tmp[WIDTH-1:0];
`else
        acc_next = tmp[WIDTH-1:0];
`endif
        ovf_next   = ovf | step_ovf;
        count_next = (&count) ? count : count + 1'b1;
    end

    // Frame control: accumulate operands in ACCUM, present the registered result in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            ovf          <= 1'b0;
            count        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc   <= acc_next;
                        ovf   <= ovf_next;
                        count <= count_next;
                        if (in_last) begin
                            state        <= DONE;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            out_acc      <= acc_next;
                            out_overflow <= ovf_next;
                            out_count    <= count_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
